hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//   Stall/flush controller for the 5-stage MIPS pipeline; counterpart of forward_memory. Forwarding
//   removes hazards without stalling; this block stalls when forwarding cannot help (load-use in ID),
//   freezes the pipe while data memory is busy, and flushes IF/ID on taken branches.
//   Sits beside the forwarding units; its outputs drive the PC and the pipeline-register enables.
// PARAMETERS
//   CNT_W        16   width of the saturating stall-cycle counter
//   WAIT_TIMEOUT 64   MEM_WAIT cycles before mem_timeout is raised (>=1)
// PORTS
//   clk              in   1      pipeline clock, rising edge
//   rst_n            in   1      asynchronous active-low reset
//   IDEX_MemRead     in   1      instruction in EX is lw
//   IDEX_RegisterRt  in   5      lw destination (rt)
//   IFID_RegisterRs  in   5      rs of instruction in ID
//   IFID_RegisterRt  in   5      rt of instruction in ID
//   IFID_UsesRt      in   1      ID instruction reads rt (R-type, beq, sw)
//   IFID_MemWrite    in   1      ID instruction is sw
//   branch_taken     in   1      branch resolved taken in ID
//   EXMEM_MemAccess  in   1      instruction in MEM accesses data memory
//   dmem_ready       in   1      data memory completes access this cycle
//   PCWrite          out  1      PC load enable
//   IFIDWrite        out  1      IF/ID load enable
//   IFID_Flush       out  1      clear IF/ID to nop
//   IDEX_Bubble      out  1      load nop control into ID/EX
//   pipe_freeze      out  1      hold ID/EX and EX/MEM; MEM/WB loads nop
//   stall_count      out  CNT_W  total stall cycles, saturating
//   mem_timeout      out  1      sticky: MEM_WAIT exceeded WAIT_TIMEOUT
// BEHAVIOUR
//   States: RUN, BUBBLE, MEM_WAIT. Reset -> RUN, stall_count=0, wait_cnt=0, mem_timeout=0.
//   Outputs combinational from state+inputs; in reset: PCWrite=IFIDWrite=1, others 0.
//   load_use = IDEX_MemRead && IDEX_RegisterRt!=0 && (IFID_RegisterRs==IDEX_RegisterRt ||
//     (IFID_UsesRt && !IFID_MemWrite && IFID_RegisterRt==IDEX_RegisterRt)).
//   sw-rt dependency on lw does NOT stall: forward_memory covers it two cycles later.
//   mem_busy = EXMEM_MemAccess && !dmem_ready. Priority: mem_busy > load_use > branch_taken.
//   RUN: mem_busy -> pipe_freeze=1, PCWrite=IFIDWrite=0, go MEM_WAIT, wait_cnt=1.
//     else load_use -> PCWrite=IFIDWrite=0, IDEX_Bubble=1, go BUBBLE.
//     else branch_taken -> IFID_Flush=1, PCWrite=1, stay RUN. else all enables 1, stay RUN.
//   BUBBLE: exactly one cycle; load_use not re-evaluated; mem_busy -> as RUN (to MEM_WAIT);
//     else normal enables, branch_taken honoured (now has forwarded operand), go RUN.
//   MEM_WAIT: pipe_freeze=1, PCWrite=IFIDWrite=0, IFID_Flush=IDEX_Bubble=0, branch_taken ignored.
//     dmem_ready=1 -> same-cycle release: pipe_freeze=0, normal RUN decode applied, go RUN.
//     wait_cnt increments each cycle; wait_cnt==WAIT_TIMEOUT -> mem_timeout=1 (sticky until reset);
//     block keeps waiting (no abort).
//   stall_count += 1 every cycle PCWrite==0; saturates at 2^CNT_W-1, never wraps.
//   rst_n low mid-stall: immediate return to RUN, enables 1, counters/flag cleared.
//   Register $0 never causes a stall.
// TESTING
//   lw $1 in EX, add rs=$1 in ID -> 1 cycle PCWrite=0, IDEX_Bubble=1, then RUN; stall_count=1.
//   lw $1 in EX, sw rt=$1 rs=$2 in ID -> no stall; lw $0 / add rs=$0 -> no stall.
//   load_use + branch_taken same cycle -> bubble only, IFID_Flush=0; next cycle flush=1.
//   EXMEM_MemAccess=1, dmem_ready=0 for 3 cycles -> pipe_freeze=1 x3, release on 4th; count=3.
//   WAIT_TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after 4th wait cycle, stays 1 after release.
//   CNT_W=4, 20 stall cycles -> stall_count=15; rst_n low in MEM_WAIT -> RUN, outputs reset values.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline stall/flush controller for load-use, data-memory wait and taken branches
module hazard_stall_unit #(
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_RegisterRt,
  input  logic [4:0]       IFID_RegisterRs,
  input  logic [4:0]       IFID_RegisterRt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_MemWrite,
  input  logic             branch_taken,
  input  logic             EXMEM_MemAccess,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);
  typedef enum logic [1:0] {RUN, BUBBLE, MEM_WAIT} state_t;
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_TIMEOUT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic             load_use, mem_busy, in_wait, decode_run;
  // an sw whose rt is the lw target is left to memory-stage forwarding, so only true ID consumers stall
  assign load_use = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
                    ((IFID_RegisterRs == IDEX_RegisterRt) ||
                     (IFID_UsesRt && !IFID_MemWrite && (IFID_RegisterRt == IDEX_RegisterRt)));
  assign mem_busy   = EXMEM_MemAccess && !dmem_ready;
  assign in_wait    = (state_q == MEM_WAIT) && !dmem_ready;
  assign decode_run = (state_q == RUN) || ((state_q == MEM_WAIT) && dmem_ready);
  assign stall_count = stall_cnt_q;
  assign mem_timeout = timeout_q;
  // state, wait counter, stall counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end
  // next state and enables: memory wait dominates, then load-use bubble, then branch flush
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = RUN;
    wait_cnt_d  = '0;
    if (in_wait) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      pipe_freeze = 1'b1;
      state_d     = MEM_WAIT;
      wait_cnt_d  = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
    end else if (mem_busy) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      pipe_freeze = 1'b1;
      state_d     = MEM_WAIT;
      wait_cnt_d  = WAIT_ONE;
    end else if (decode_run && load_use) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEX_Bubble = 1'b1;
      state_d     = BUBBLE;
    end else begin
      IFID_Flush  = branch_taken;
    end
    if (!rst_n) begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      pipe_freeze = 1'b0;
    end
    stall_cnt_d = (!PCWrite && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    timeout_d   = timeout_q || ((state_d == MEM_WAIT) && (wait_cnt_d == WAIT_MAX));
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors with a scoreboard queue checked by an independent monitor
module tb_hazard_stall_unit;
  logic       clk = 1'b0;
  logic       rst_n, mr, uses_rt, mw, br, acc, rdy;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       pcw, ifw, flush, bubble, freeze, timeout;
  logic [3:0] cnt;
  typedef struct {
    string      name;
    logic [4:0] ctl;
    logic [3:0] cnt;
    logic       to;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int fails  = 0;
  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] BRF = 5'b11100;
  localparam logic [4:0] LU  = 5'b00010;
  localparam logic [4:0] FZ  = 5'b00001;

  hazard_stall_unit #(.CNT_W(4), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDEX_MemRead(mr), .IDEX_RegisterRt(ex_rt),
    .IFID_RegisterRs(id_rs), .IFID_RegisterRt(id_rt),
    .IFID_UsesRt(uses_rt), .IFID_MemWrite(mw),
    .branch_taken(br), .EXMEM_MemAccess(acc), .dmem_ready(rdy),
    .PCWrite(pcw), .IFIDWrite(ifw), .IFID_Flush(flush), .IDEX_Bubble(bubble),
    .pipe_freeze(freeze), .stall_count(cnt), .mem_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic rn, m, input logic [4:0] ert, rs, rt,
                      input logic urt, w, b, a, r, input logic [4:0] ctl,
                      input logic [3:0] c, input logic to);
    @(posedge clk);
    #1;
    rst_n = rn; mr = m; ex_rt = ert; id_rs = rs; id_rt = rt;
    uses_rt = urt; mw = w; br = b; acc = a; rdy = r;
    sb.push_back('{nm, ctl, c, to});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({pcw, ifw, flush, bubble, freeze} !== e.ctl) begin
        fails++;
        $display("FAIL %s ctl {pcw,ifw,flush,bubble,freeze} got %b expected %b", e.name, {pcw, ifw, flush, bubble, freeze}, e.ctl);
      end
      checks++;
      if (cnt !== e.cnt) begin
        fails++;
        $display("FAIL %s stall_count got %0d expected %0d", e.name, cnt, e.cnt);
      end
      checks++;
      if (timeout !== e.to) begin
        fails++;
        $display("FAIL %s mem_timeout got %b expected %b", e.name, timeout, e.to);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mr = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    uses_rt = 1'b0; mw = 1'b0; br = 1'b0; acc = 1'b0; rdy = 1'b0;
    //   name        rn mr ert rs rt urt mw br acc rdy  ctl  cnt to
    step("reset",    0, 1, 1,  1, 0, 0,  0, 0, 0,  0,   NRM, 0, 0);
    step("idle",     1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 0, 0);
    step("lu_rs",    1, 1, 1,  1, 2, 1,  0, 0, 0,  0,   LU,  0, 0);
    step("bub_exit", 1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 1, 0);
    step("run",      1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 1, 0);
    step("sw_rt",    1, 1, 1,  2, 1, 1,  1, 0, 0,  0,   NRM, 1, 0);
    step("lu_rt",    1, 1, 1,  2, 1, 1,  0, 0, 0,  0,   LU,  1, 0);
    step("bub2",     1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 2, 0);
    step("lw_r0",    1, 1, 0,  0, 0, 1,  0, 0, 0,  0,   NRM, 2, 0);
    step("add_rs0",  1, 1, 1,  0, 0, 1,  0, 0, 0,  0,   NRM, 2, 0);
    step("rt_unused",1, 1, 3,  4, 3, 0,  0, 0, 0,  0,   NRM, 2, 0);
    step("lu_br",    1, 1, 5,  5, 0, 0,  0, 1, 0,  0,   LU,  2, 0);
    step("bub_br",   1, 1, 5,  5, 0, 0,  0, 1, 0,  0,   BRF, 3, 0);
    step("br_run",   1, 0, 0,  0, 0, 0,  0, 1, 0,  0,   BRF, 3, 0);
    step("mem1",     1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  3, 0);
    step("mem2_br",  1, 0, 0,  0, 0, 0,  0, 1, 1,  0,   FZ,  4, 0);
    step("mem3",     1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  5, 0);
    step("mem_rel",  1, 0, 0,  0, 0, 0,  0, 0, 1,  1,   NRM, 6, 0);
    step("run2",     1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 6, 0);
    step("to1",      1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  6, 0);
    step("to2",      1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  7, 0);
    step("to3",      1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  8, 0);
    step("to4",      1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  9, 0);
    step("to5",      1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  10, 1);
    step("to_rel_br",1, 0, 0,  0, 0, 0,  0, 1, 0,  1,   BRF, 11, 1);
    step("sticky",   1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 11, 1);
    step("sat_in",   1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  11, 1);
    for (int i = 0; i < 8; i++)
      step("sat_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, (12 + i > 15) ? 4'd15 : 4'(12 + i), 1);
    step("sat_rel",  1, 0, 0,  0, 0, 0,  0, 0, 0,  1,   NRM, 15, 1);
    step("m1",       1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  15, 1);
    step("m2",       1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  15, 1);
    step("rst_wait", 0, 0, 0,  0, 0, 0,  0, 0, 1,  0,   NRM, 0, 0);
    step("post_rst", 1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 0, 0);
    step("lu_again", 1, 1, 7,  7, 0, 0,  0, 0, 0,  0,   LU,  0, 0);
    step("bub_mem",  1, 0, 0,  0, 0, 0,  0, 0, 1,  0,   FZ,  1, 0);
    step("bm_rel",   1, 0, 0,  0, 0, 0,  0, 0, 1,  1,   NRM, 2, 0);
    step("final",    1, 0, 0,  0, 0, 0,  0, 0, 0,  0,   NRM, 2, 0);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain scoreboard entries left %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
